saida_display: RTL and testbench

- Downstream consumer of the processor I/O module's registered output word `Saida`.
- Converts the 32-bit word, signed or unsigned, to decimal with a sequential double-dabble (shift/add-3) engine.
- Drives DIGITS active-low seven-segment displays with leading-zero blanking, a minus sign and an overflow indication.
- Sits between the I/O module and the board HEX displays.

---
 rtl/saida_display.sv | 172 +++++++++++++++++
 tb/tb_saida_display.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/saida_display.sv
// saida_display: converts the I/O module output word to decimal with a
// sequential double-dabble engine and drives active-low seven-segment digits
// with leading-zero blanking, a minus sign and an overflow "E".
module saida_display #(
    parameter int unsigned DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           Saida,
    input  logic                  signed_mode,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  busy,
    output logic                  updated
);

    localparam int unsigned SEG_W  = 7 * DIGITS;
    localparam int unsigned BCD_N  = 10;
    localparam int unsigned BCD_W  = 4 * BCD_N;
    localparam logic [6:0]  BLANK  = 7'b1111111;
    localparam logic [6:0]  MINUS  = 7'b0111111;
    localparam logic [6:0]  GLYPH_E = 7'b0000110;
    localparam logic [3:0]  DIGITS_4 = 4'(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_FORMAT
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        saida_q, saida_d;
    logic               mode_q, mode_d;
    logic               pending_q, pending_d;
    logic [31:0]        mag_q, mag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic               busy_q, busy_d;
    logic               updated_q, updated_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [SEG_W-1:0]   seg_img;
    logic [3:0]         nd;
    logic [3:0]         need;
    logic               neg;
    logic               ovf;

    // Active-low gfedcba glyph for one BCD digit
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = BLANK;
        endcase
    endfunction

    // Add-3 correction on every BCD nibble of 5 or more before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(BCD_N); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Display image from the finished BCD value and captured sign
    always_comb begin
        nd = 4'd1;
        for (int i = 0; i < int'(BCD_N); i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                nd = 4'(i + 1);
            end
        end
        neg     = mode_q & saida_q[31];
        need    = nd + {3'b000, neg};
        ovf     = (need > DIGITS_4);
        seg_img = '1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (ovf) begin
                seg_img[7*k +: 7] = (k == 0) ? GLYPH_E : BLANK;
            end else if (4'(k) < nd) begin
                seg_img[7*k +: 7] = glyph(bcd_q[4*k +: 4]);
            end else if (neg && (4'(k) == nd)) begin
                seg_img[7*k +: 7] = MINUS;
            end
        end
    end

    // Next-state and datapath for the capture / shift / format sequence
    always_comb begin
        state_d   = state_q;
        saida_d   = saida_q;
        mode_d    = mode_q;
        pending_d = pending_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        seg_d     = seg_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q || (Saida != saida_q) || (signed_mode != mode_q)) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                saida_d   = Saida;
                mode_d    = signed_mode;
                pending_d = 1'b0;
                mag_d     = (signed_mode && Saida[31]) ? (~Saida + 32'd1) : Saida;
                bcd_d     = '0;
                cnt_d     = 5'd0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                {bcd_d, mag_d} = {bcd_adj[BCD_W-2:0], mag_q, 1'b0};
                cnt_d          = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_FORMAT;
                end
            end
            S_FORMAT: begin
                seg_d   = seg_img;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d    = (state_d == S_LOAD) || (state_d == S_SHIFT);
        updated_d = (state_q == S_FORMAT);
    end

    // State and output registers; reset blanks the display and arms a conversion
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            saida_q   <= 32'd0;
            mode_q    <= 1'b0;
            pending_q <= 1'b1;
            mag_q     <= 32'd0;
            bcd_q     <= '0;
            cnt_q     <= 5'd0;
            seg_q     <= '1;
            busy_q    <= 1'b0;
            updated_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            saida_q   <= saida_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            seg_q     <= seg_d;
            busy_q    <= busy_d;
            updated_q <= updated_d;
        end
    end

    assign seg     = seg_q;
    assign busy    = busy_q;
    assign updated = updated_q;

endmodule

// File: tb/tb_saida_display.sv
// Testbench for saida_display: arithmetic reference model feeds a scoreboard
// of expected display images, compared on every updated pulse.
module tb_saida_display;

    localparam int unsigned DIGITS = 8;
    localparam int unsigned SEG_W  = 7 * DIGITS;

    logic               clock;
    logic               reset;
    logic [31:0]        Saida;
    logic               signed_mode;
    logic [SEG_W-1:0]   seg;
    logic               busy;
    logic               updated;

    int n_checks;
    int n_fail;
    logic [SEG_W-1:0] sb[$];

    saida_display #(.DIGITS(DIGITS)) dut (
        .clock       (clock),
        .reset       (reset),
        .Saida       (Saida),
        .signed_mode (signed_mode),
        .seg         (seg),
        .busy        (busy),
        .updated     (updated)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference image computed with plain integer arithmetic
    function automatic logic [SEG_W-1:0] model(input logic [31:0] w, input bit m);
        logic [6:0] gl [10];
        longint unsigned v;
        int d [10];
        int nd;
        bit neg;
        logic [SEG_W-1:0] img;
        gl[0] = 7'b1000000; gl[1] = 7'b1111001; gl[2] = 7'b0100100; gl[3] = 7'b0110000;
        gl[4] = 7'b0011001; gl[5] = 7'b0010010; gl[6] = 7'b0000010; gl[7] = 7'b1111000;
        gl[8] = 7'b0000000; gl[9] = 7'b0010000;
        neg = m && w[31];
        v   = {32'd0, w};
        if (neg) v = 64'h1_0000_0000 - v;
        nd = 1;
        for (int i = 0; i < 10; i++) begin
            d[i] = int'(v % 10);
            v    = v / 10;
            if (d[i] != 0) nd = i + 1;
        end
        img = '1;
        if (nd + int'(neg) > int'(DIGITS)) begin
            img[6:0] = 7'b0000110;
        end else begin
            for (int k = 0; k < nd; k++) img[7*k +: 7] = gl[d[k]];
            if (neg) img[7*nd +: 7] = 7'b0111111;
        end
        return img;
    endfunction

    // Wait (bounded) for the next updated pulse, sampled on falling edges
    task automatic wait_upd(input int limit, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < limit) begin
            @(negedge clock);
            cyc++;
            if (updated === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [SEG_W-1:0] exp_s;
        bit done;
        int c;
        reset = 1'b0; Saida = 32'd0; signed_mode = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (seg !== '1) begin n_fail++; $display("FAIL reset_seg actual=%h expected=all ones", seg); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b expected=0", busy); end
        n_checks++; if (updated !== 1'b0) begin n_fail++; $display("FAIL reset_updated actual=%b expected=0", updated); end
        sb.push_back(model(32'd0, 1'b0));
        reset = 1'b1;
        done = 1'b0; c = 0;
        while (!done && c < 60) begin
            @(negedge clock); c++;
            if (c == 1 || c == 33) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_hi cycle=%0d actual=%b expected=1", c, busy); end
            end
            if (updated === 1'b1) done = 1'b1;
        end
        n_checks++;
        if (!done || c != 35) begin n_fail++; $display("FAIL reset_latency actual=%0d expected=35", c); end
        exp_s = sb.pop_front();
        n_checks++; if (seg !== exp_s) begin n_fail++; $display("FAIL reset_zero_seg actual=%h expected=%h", seg, exp_s); end
        n_checks++; if (seg[6:0] !== 7'b1000000) begin n_fail++; $display("FAIL reset_digit0 actual=%b expected=1000000", seg[6:0]); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done actual=%b expected=0", busy); end
        @(negedge clock);
        n_checks++; if (updated !== 1'b0) begin n_fail++; $display("FAIL updated_width actual=%b expected=0", updated); end
    endtask

    task automatic test_unsigned();
        logic [SEG_W-1:0] exp_s;
        logic [SEG_W-1:0] lit;
        bit ok; int cyc;
        Saida = 32'h0000_007B; signed_mode = 1'b0;
        sb.push_back(model(Saida, signed_mode));
        wait_upd(60, ok, cyc);
        exp_s = sb.pop_front();
        n_checks++; if (!ok || cyc != 35) begin n_fail++; $display("FAIL u123_latency actual=%0d expected=35", cyc); end
        n_checks++; if (seg !== exp_s) begin n_fail++; $display("FAIL u123_model actual=%h expected=%h", seg, exp_s); end
        lit = '1;
        lit[20:14] = 7'b1111001; lit[13:7] = 7'b0100100; lit[6:0] = 7'b0110000;
        n_checks++; if (seg !== lit) begin n_fail++; $display("FAIL u123_literal actual=%h expected=%h", seg, lit); end
    endtask

    task automatic test_signed();
        logic [SEG_W-1:0] exp_s;
        logic [SEG_W-1:0] lit;
        bit ok; int cyc;
        Saida = 32'hFFFF_FF85; signed_mode = 1'b1;
        sb.push_back(model(Saida, signed_mode));
        wait_upd(60, ok, cyc);
        exp_s = sb.pop_front();
        lit = '1;
        lit[27:21] = 7'b0111111; lit[20:14] = 7'b1111001; lit[13:7] = 7'b0100100; lit[6:0] = 7'b0110000;
        n_checks++; if (!ok || seg !== exp_s) begin n_fail++; $display("FAIL neg123_model ok=%0b actual=%h expected=%h", ok, seg, exp_s); end
        n_checks++; if (seg !== lit) begin n_fail++; $display("FAIL neg123_literal actual=%h expected=%h", seg, lit); end
        signed_mode = 1'b0;
        sb.push_back(model(Saida, signed_mode));
        wait_upd(60, ok, cyc);
        exp_s = sb.pop_front();
        lit = '1; lit[6:0] = 7'b0000110;
        n_checks++; if (!ok || cyc != 35) begin n_fail++; $display("FAIL mode_change_latency actual=%0d expected=35", cyc); end
        n_checks++; if (seg !== lit || seg !== exp_s) begin n_fail++; $display("FAIL unsigned_big_E actual=%h expected=%h", seg, lit); end
    endtask

    task automatic test_boundary();
        logic [31:0] words [4];
        bit          modes [4];
        logic [SEG_W-1:0] exp_s;
        bit ok; int cyc;
        words[0] = 32'h05F5_E0FF; modes[0] = 1'b0;
        words[1] = 32'h05F5_E100; modes[1] = 1'b0;
        words[2] = 32'hFF67_6981; modes[2] = 1'b1;
        words[3] = 32'h8000_0000; modes[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            Saida = words[i]; signed_mode = modes[i];
            sb.push_back(model(words[i], modes[i]));
            wait_upd(60, ok, cyc);
            exp_s = sb.pop_front();
            n_checks++;
            if (!ok || seg !== exp_s) begin
                n_fail++;
                $display("FAIL boundary_%0d word=%h ok=%0b actual=%h expected=%h", i, words[i], ok, seg, exp_s);
            end
        end
        n_checks++; if (seg[6:0] !== 7'b0000110 || seg[SEG_W-1:7] !== '1) begin n_fail++; $display("FAIL min_signed_E actual=%h", seg); end
    endtask

    task automatic test_back_to_back();
        logic [SEG_W-1:0] exp_s;
        int c; int n_upd;
        int upd_at [2];
        Saida = 32'd5; signed_mode = 1'b0;
        sb.push_back(model(32'd5, 1'b0));
        c = 0; n_upd = 0;
        while (n_upd < 2 && c < 120) begin
            @(negedge clock); c++;
            if (c == 12) Saida = 32'd7;
            if (c == 17) begin Saida = 32'd9; sb.push_back(model(32'd9, 1'b0)); end
            if (updated === 1'b1) begin
                upd_at[n_upd] = c;
                exp_s = (sb.size() > 0) ? sb.pop_front() : '0;
                n_checks++;
                if (seg !== exp_s) begin n_fail++; $display("FAIL b2b_update_%0d actual=%h expected=%h", n_upd, seg, exp_s); end
                n_upd++;
            end
        end
        n_checks++;
        if (n_upd != 2 || upd_at[0] != 35 || upd_at[1] != 70) begin
            n_fail++;
            $display("FAIL b2b_timing updates=%0d first=%0d second=%0d expected 2 at 35 and 70", n_upd, upd_at[0], upd_at[1]);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        logic [SEG_W-1:0] exp_s;
        bit ok; int cyc;
        Saida = 32'd42; signed_mode = 1'b0;
        repeat (16) @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++; if (seg !== '1) begin n_fail++; $display("FAIL midreset_seg actual=%h expected=all ones", seg); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy actual=%b expected=0", busy); end
        @(negedge clock);
        sb.push_back(model(32'd42, 1'b0));
        reset = 1'b1;
        wait_upd(60, ok, cyc);
        exp_s = sb.pop_front();
        n_checks++; if (!ok || cyc != 35) begin n_fail++; $display("FAIL midreset_latency actual=%0d expected=35", cyc); end
        n_checks++; if (seg !== exp_s) begin n_fail++; $display("FAIL midreset_42 actual=%h expected=%h", seg, exp_s); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
